shifter_rr_scheduler: RTL and testbench

Time-shares one external leading-one normaliser (num in, k/m1 out, purely combinational) between NUM_REQ requesters. Uses round-robin arbitration and valid/ready handshakes. Registers the normaliser input, captures k/m1 one cycle later and returns them tagged with the requester id. Sits between the log-domain operand sources and the single normaliser instance in the datapath.

---
 rtl/shifter_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_shifter_rr_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_rr_scheduler.sv
// Round-robin scheduler sharing one combinational leading-one normaliser between NUM_REQ requesters.
// Optional build macro SHIFTER_SCHED_PRIO0_EN gives requester 0 fixed top priority over the round-robin group.

`ifndef NUM_LENGTH
`define NUM_LENGTH 32
`endif
`ifndef K_LENGTH
`define K_LENGTH 5
`endif
`ifndef M1_LENGTH
`define M1_LENGTH 8
`endif

module shifter_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int NUM_W   = `NUM_LENGTH,
  parameter int K_W     = `K_LENGTH,
  parameter int M1_W    = `M1_LENGTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*NUM_W-1:0] req_num,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_W-1:0]         sh_num,
  input  logic [K_W-1:0]           sh_k,
  input  logic [M1_W-1:0]          sh_m1,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [K_W-1:0]           rsp_k,
  output logic [M1_W-1:0]          rsp_m1,
  output logic                     rsp_zero,
  input  logic                     rsp_ready
);

`ifdef SHIFTER_SCHED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic              zero_reg;
  logic [NUM_W-1:0]  sh_num_reg;
  logic              rsp_valid_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [K_W-1:0]    rsp_k_reg;
  logic [M1_W-1:0]   rsp_m1_reg;
  logic              rsp_zero_reg;

  logic [NUM_W-1:0]  num_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt_vec;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   ptr_next;
  logic              can_accept;
  logic              accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign num_arr[gi] = req_num[gi*NUM_W +: NUM_W];
    end
  endgenerate

  // First valid requester at or above the pointer, wrapping; requester 0 is
  // excluded from the rotation when it owns the fixed-priority slot.
  always_comb begin
    logic found;
    gnt_vec = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    if (PRIO0 && req_valid[0]) begin
      gnt_vec[0] = 1'b1;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        cand = ID_W'((int'(ptr_reg) + off) % NUM_REQ);
        if (!found && req_valid[cand] && !(PRIO0 && cand == '0)) begin
          gnt_vec[cand] = 1'b1;
          gnt_idx       = cand;
          found         = 1'b1;
        end
      end
    end
  end

  assign can_accept = (state_reg == IDLE) || (state_reg == RESP && rsp_ready);
  assign req_ready  = {NUM_REQ{can_accept && rst_n}} & gnt_vec;
  assign accept     = |(req_valid & req_ready);
  assign ptr_next   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      zero_reg      <= 1'b0;
      sh_num_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_k_reg     <= '0;
      rsp_m1_reg    <= '0;
      rsp_zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        EVAL: begin
          rsp_k_reg     <= sh_k;
          rsp_m1_reg    <= sh_m1;
          rsp_id_reg    <= id_reg;
          rsp_zero_reg  <= zero_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // An accept in RESP overrides the drop to IDLE: back-to-back operation.
      if (accept) begin
        sh_num_reg <= num_arr[gnt_idx];
        id_reg     <= gnt_idx;
        zero_reg   <= (num_arr[gnt_idx] == '0);
        if (!(PRIO0 && gnt_idx == '0))
          ptr_reg <= ptr_next;
        state_reg  <= EVAL;
      end
    end
  end

  assign sh_num    = sh_num_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_k     = rsp_k_reg;
  assign rsp_m1    = rsp_m1_reg;
  assign rsp_zero  = rsp_zero_reg;

endmodule

// File: tb/tb_shifter_rr_scheduler.sv
// Scoreboard bench for shifter_rr_scheduler with a golden leading-one normaliser on sh_num.
module tb_shifter_rr_scheduler;
  localparam int N = 4, IDW = 2, NW = 32, KW = 5, MW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*NW-1:0]   req_num;
  logic [NW-1:0]     sh_num;
  logic [KW-1:0]     sh_k;
  logic [MW-1:0]     sh_m1;
  logic              rsp_valid, rsp_zero, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [KW-1:0]     rsp_k;
  logic [MW-1:0]     rsp_m1;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [KW-1:0]  k;
    logic [MW-1:0]  m1;
    logic           zero;
  } rsp_t;

  rsp_t exp_q[$];
  int   acc_id[$], acc_cyc[$], rsp_id_log[$], rsp_cyc[$];
  int   total = 0, bad = 0, cyc = 0;

  shifter_rr_scheduler #(.NUM_REQ(N), .ID_W(IDW), .NUM_W(NW), .K_W(KW), .M1_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_num(req_num), .req_ready(req_ready),
    .sh_num(sh_num), .sh_k(sh_k), .sh_m1(sh_m1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_k(rsp_k), .rsp_m1(rsp_m1), .rsp_zero(rsp_zero), .rsp_ready(rsp_ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden normaliser: k = leading-one index, m1 = the MW bits just below it.
  function automatic logic [KW+MW-1:0] norm(input logic [NW-1:0] n);
    logic [KW-1:0] k;
    logic [63:0]   t;
    k = '0;
    for (int b = 0; b < NW; b++) if (n[b]) k = KW'(b);
    t = {n, 32'd0} >> k;
    return {k, t[31:24]};
  endfunction

  assign {sh_k, sh_m1} = norm(sh_num);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acceptance side of the scoreboard.
  always @(negedge clk) begin
    logic [NW-1:0] n;
    rsp_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("req_ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          n = req_num[i*NW +: NW];
          e.id = IDW'(i);
          {e.k, e.m1} = norm(n);
          e.zero = (n == 0);
          exp_q.push_back(e);
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  // Response side of the scoreboard.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      $display("rsp id=%0d k=%0d m1=%02h zero=%0d cyc=%0d", rsp_id, rsp_k, rsp_m1, rsp_zero, cyc);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_id", 64'(rsp_id), 64'(e.id));
        chk("sb_k", 64'(rsp_k), 64'(e.k));
        chk("sb_m1", 64'(rsp_m1), 64'(e.m1));
        chk("sb_zero", 64'(rsp_zero), 64'(e.zero));
      end
      rsp_id_log.push_back(int'(rsp_id));
      rsp_cyc.push_back(cyc);
    end
  end

  task automatic single(input int i, input logic [NW-1:0] num, input int ek, input int em, input bit ez);
    req_num[i*NW +: NW] = num;
    req_valid = N'(1) << i;
    rsp_ready = 1'b1;
    #1 chk("single_ready", 64'(req_ready), 64'(N'(1) << i));
    step();
    req_valid = '0;
    chk("single_lat1_valid", 64'(rsp_valid), 64'd0);
    chk("single_sh_num", 64'(sh_num), 64'(num));
    step();
    chk("single_valid", 64'(rsp_valid), 64'd1);
    chk("single_id", 64'(rsp_id), 64'(i));
    chk("single_k", 64'(rsp_k), 64'(ek));
    chk("single_m1", 64'(rsp_m1), 64'(em));
    chk("single_zero", 64'(rsp_zero), 64'(ez));
    step();
    chk("single_done", 64'(rsp_valid), 64'd0);
  endtask

  task automatic collect(input int cnt, input int exp_order[8], input string name);
    for (int c = 0; c < 80 && acc_id.size() < cnt; c++) step();
    chk({name, "_accepts"}, 64'(acc_id.size()), 64'(cnt));
    step();
    req_valid = '0;
    repeat (3) step();
    chk({name, "_rsps"}, 64'(rsp_id_log.size()), 64'(cnt));
    for (int k = 0; k < cnt && k < acc_id.size(); k++) begin
      chk({name, "_grant"}, 64'(acc_id[k]), 64'(exp_order[k]));
      if (k > 0) chk({name, "_spacing"}, 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd2);
      if (k < rsp_id_log.size()) begin
        chk({name, "_rsp_id"}, 64'(rsp_id_log[k]), 64'(exp_order[k]));
        chk({name, "_latency"}, 64'(rsp_cyc[k] - acc_cyc[k]), 64'd2);
      end
    end
  endtask

  initial begin
    int ord_rr[8], ord_p[8];
`ifdef SHIFTER_SCHED_PRIO0_EN
    ord_rr = '{0, 0, 0, 0, 0, 0, 0, 0};
    ord_p  = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    ord_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    ord_p  = '{3, 0, 3, 0, 0, 0, 0, 0};
`endif
    rst_n = 1'b0; req_valid = '1; req_num = '0; rsp_ready = 1'b0;
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_k", 64'(rsp_k), 64'd0);
    chk("rst_rsp_m1", 64'(rsp_m1), 64'd0);
    chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("rst_sh_num", 64'(sh_num), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    repeat (5) begin
      step();
      chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("idle_req_ready", 64'(req_ready), 64'd0);
    end

    single(2, 32'hC000_0000, 31, 8'h80, 1'b0);
    single(0, 32'h0000_0000, 0, 8'h00, 1'b1);
    single(0, 32'h0000_0001, 0, 8'h00, 1'b0);

    // Reset pulse so the rotation starts from requester 0.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    acc_id.delete(); acc_cyc.delete(); rsp_id_log.delete(); rsp_cyc.delete();
    req_num = {32'h0000_00FF, 32'h8000_0001, 32'h0001_2345, 32'h0000_0010};
    req_valid = '1;
    rsp_ready = 1'b1;
    collect(8, ord_rr, "rr");

    // Backpressure with requester 1 waiting.
    rsp_ready = 1'b0;
    req_num[3*NW +: NW] = 32'h0000_0100;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    req_num[1*NW +: NW] = 32'h0F00_0000;
    req_valid = 4'b0010;
    repeat (6) begin
      #1;
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd3);
      chk("bp_k", 64'(rsp_k), 64'd8);
      chk("bp_m1", 64'(rsp_m1), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_sh_num", 64'(sh_num), 64'h100);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    chk("bp_sh_num_new", 64'(sh_num), 64'h0F00_0000);
    chk("bp_valid_drop", 64'(rsp_valid), 64'd0);
    step();
    chk("bp_rsp2_valid", 64'(rsp_valid), 64'd1);
    chk("bp_rsp2_id", 64'(rsp_id), 64'd1);
    chk("bp_rsp2_k", 64'(rsp_k), 64'd27);
    chk("bp_rsp2_m1", 64'(rsp_m1), 64'hE0);
    step();

    // Asynchronous reset while in EVAL.
    req_num[2*NW +: NW] = 32'h0000_0005;
    req_valid = 4'b0100;
    step();
    req_valid = '1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_sh_num", 64'(sh_num), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    req_valid = '0;
    repeat (4) begin
      step();
      chk("arst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    req_valid = 4'b1010;
    #1 chk("arst_ptr0", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    repeat (3) step();

    // Requesters 0 and 3 both valid.
    acc_id.delete(); acc_cyc.delete(); rsp_id_log.delete(); rsp_cyc.delete();
    req_num[0*NW +: NW] = 32'h0000_0003;
    req_num[3*NW +: NW] = 32'h4000_0000;
    req_valid = 4'b1001;
    collect(4, ord_p, "p03");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
